// File: rtl/axi_lite_uart_rx_if.sv
// AXI-lite slave bus bundle for axi_lite_uart_rx: the write address, write data,
// write response, read address and read data channels.
interface axi_lite_uart_rx_if #(
  parameter int C_S_AXI_ADDR_WIDTH = 64,
  parameter int C_S_AXI_DATA_WIDTH = 64
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr;
  logic                            awvalid;
  logic                            awready;
  logic [C_S_AXI_DATA_WIDTH-1:0]   wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                            wvalid;
  logic                            wready;
  logic [1:0]                      bresp;
  logic                            bvalid;
  logic                            bready;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr;
  logic                            arvalid;
  logic                            arready;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                      rresp;
  logic                            rvalid;
  logic                            rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_uart_rx.sv
// AXI-lite MMIO UART receiver: 8N1 serial input into a small FIFO, polled or read by software.
// Define UART_RX_PARITY_EN for 8E1 framing with a PARITY state and a live PERR sticky bit.
module axi_lite_uart_rx #(
  parameter int C_S_AXI_ADDR_WIDTH = 64,
  parameter int C_S_AXI_DATA_WIDTH = 64,
  parameter int CLK_PER_BIT        = 16,
  parameter int FIFO_DEPTH         = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  axi_lite_uart_rx_if.slave       s,
  input  logic                    uart_rxd,
  output logic                    irq
);
  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int DW    = C_S_AXI_DATA_WIDTH;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
  localparam logic [2:0] AFTER_DATA = PARITY;
`else
  localparam logic [2:0] AFTER_DATA = STOP;
`endif

  logic             rxd_meta, rxd_sync, rxd_prev;
  logic [2:0]       state;
  logic [CNT_W-1:0] baud_cnt, tick_at;
  logic             tick;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             stop_wait, par_bad;
  logic             push_req, ferr_set, perr_set, ovr_set, do_push, pop, flush, clr;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             empty, full;
  logic             ie, ovr, ferr, perr, live;
  logic             ar_hs, wr_hs, ctrl_wr;
  logic [DW-1:0]    rd_word;

  // NOTE: every clocked block uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  // START waits half a bit to land mid-bit; every later sample is a full bit apart.
  assign tick_at = (state == START) ? CNT_W'(CLK_PER_BIT/2 - 1) : CNT_W'(CLK_PER_BIT - 1);
  assign tick    = (baud_cnt == tick_at);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      stop_wait <= 1'b0;
      par_bad   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt  <= '0;
          bit_cnt   <= '0;
          stop_wait <= 1'b0;
          par_bad   <= 1'b0;
          if (rxd_prev && !rxd_sync) state <= START;
        end
        START: begin
          if (tick) begin
            baud_cnt <= '0;
            state    <= rxd_sync ? IDLE : DATA;
          end else baud_cnt <= baud_cnt + 1'b1;
        end
        DATA: begin
          if (tick) begin
            baud_cnt <= '0;
            shift    <= {rxd_sync, shift[7:1]};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= AFTER_DATA;
          end else baud_cnt <= baud_cnt + 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            baud_cnt <= '0;
            par_bad  <= ^{shift, rxd_sync};
            state    <= STOP;
          end else baud_cnt <= baud_cnt + 1'b1;
        end
`endif
        STOP: begin
          if (stop_wait) begin
            if (rxd_sync) state <= IDLE;
          end else if (tick) begin
            baud_cnt <= '0;
            if (rxd_sync) state <= IDLE;
            else          stop_wait <= 1'b1;
          end else baud_cnt <= baud_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign push_req = (state == STOP) && !stop_wait && tick && rxd_sync && !par_bad;
  assign ferr_set = (state == STOP) && !stop_wait && tick && !rxd_sync;
`ifdef UART_RX_PARITY_EN
  assign perr_set = (state == PARITY) && tick && ^{shift, rxd_sync};
`else
  assign perr_set = 1'b0;
`endif

  // Bus-side decode. live holds the ready outputs low while and just after reset.
  assign s.arready = live && !s.rvalid;
  assign s.awready = live && s.awvalid && s.wvalid && !s.bvalid;
  assign s.wready  = s.awready;
  assign s.bresp   = 2'b00;
  assign s.rresp   = 2'b00;
  assign ar_hs     = s.arvalid && s.arready;
  assign wr_hs     = s.awready;
  assign ctrl_wr   = wr_hs && (s.awaddr[4:3] == 2'd2);
  assign flush     = ctrl_wr && s.wdata[2];
  assign clr       = ctrl_wr && s.wdata[1];

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign pop     = ar_hs && (s.araddr[4:3] == 2'd0) && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_req && !flush && (!full || pop);
  assign ovr_set = push_req && !flush && full && !pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(pop);
    end
  end

  // NOTE: FIFO storage has no reset; count and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      live <= 1'b0;
      ie   <= 1'b0;
      ovr  <= 1'b0;
      ferr <= 1'b0;
      perr <= 1'b0;
      irq  <= 1'b0;
    end else begin
      live <= 1'b1;
      if (ctrl_wr) ie <= s.wdata[0];
      if (clr) begin
        ovr  <= 1'b0;
        ferr <= 1'b0;
        perr <= 1'b0;
      end
      if (ovr_set)  ovr  <= 1'b1;
      if (ferr_set) ferr <= 1'b1;
      if (perr_set) perr <= 1'b1;
      irq <= ie && !empty;
    end
  end

  // NOTE: rd_word gets a full default first so no path through the case infers a latch.
  always_comb begin
    rd_word = '0;
    case (s.araddr[4:3])
      2'd0: begin
        if (empty) rd_word[DW-1] = 1'b1;
        else       rd_word[7:0]  = mem[rd_ptr];
      end
      2'd1: begin
        rd_word[4:0]  = {perr, ferr, ovr, full, !empty};
        rd_word[12:8] = 5'(count);
      end
      2'd2:    rd_word[0] = ie;
      default: rd_word    = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s.rvalid <= 1'b0;
      s.rdata  <= '0;
      s.bvalid <= 1'b0;
    end else begin
      if (ar_hs) begin
        s.rvalid <= 1'b1;
        s.rdata  <= rd_word;
      end else if (s.rready) begin
        s.rvalid <= 1'b0;
      end
      if (wr_hs)         s.bvalid <= 1'b1;
      else if (s.bready) s.bvalid <= 1'b0;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{s.wstrb, s.wdata[DW-1:3], s.awaddr[C_S_AXI_ADDR_WIDTH-1:5],
                         s.awaddr[2:0], s.araddr[C_S_AXI_ADDR_WIDTH-1:5], s.araddr[2:0]};
endmodule

// File: tb/tb_axi_lite_uart_rx.sv
// Directed bench for axi_lite_uart_rx: serial frames in, AXI-lite register reads and writes out.
module tb_axi_lite_uart_rx;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rstn;
  logic uart_rxd;
  logic irq;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  axi_lite_uart_rx_if #(.C_S_AXI_ADDR_WIDTH(64), .C_S_AXI_DATA_WIDTH(64)) bus ();

  axi_lite_uart_rx #(
    .C_S_AXI_ADDR_WIDTH(64),
    .C_S_AXI_DATA_WIDTH(64),
    .CLK_PER_BIT(CPB),
    .FIFO_DEPTH(8)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .s(bus),
    .uart_rxd(uart_rxd),
    .irq(irq)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic axi_read(input logic [63:0] addr, output logic [63:0] data);
    int n;
    @(negedge clk);
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b1;
    n = 0;
    while (!bus.arready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 100) begin @(negedge clk); n++; end
    total++;
    if (!bus.rvalid) $display("FAIL read_timeout: rvalid=0 required 1 at addr %h", addr);
    else passed++;
    data = bus.rdata;
    @(negedge clk);
    bus.rready = 1'b0;
  endtask

  task automatic axi_write(input logic [63:0] addr, input logic [63:0] data);
    int n;
    @(negedge clk);
    bus.awaddr  = addr;
    bus.wdata   = data;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    bus.bready  = 1'b1;
    n = 0;
    while (!bus.awready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 100) begin @(negedge clk); n++; end
    total++;
    if (!bus.bvalid || bus.bresp !== 2'b00)
      $display("FAIL write_resp: bvalid=%0b bresp=%0b required 1/00", bus.bvalid, bus.bresp);
    else passed++;
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] d;
    #1;
    total++;
    if ({bus.arready, bus.awready, bus.rvalid, bus.bvalid, irq} !== 5'b0 || bus.rdata !== 64'h0)
      $display("FAIL reset_outputs: ar/aw/r/b/irq=%b rdata=%h required 00000/0",
               {bus.arready, bus.awready, bus.rvalid, bus.bvalid, irq}, bus.rdata);
    else passed++;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    axi_read(64'h08, d);
    total++;
    if (d !== 64'h0) $display("FAIL reset_status: got %h required 0", d); else passed++;
  endtask

  task automatic test_single_byte();
    logic [63:0] d;
    send_frame(8'hA5, 1'b1);
    axi_read(64'h08, d);
    total++;
    if (d !== 64'h101) $display("FAIL single_status: got %h required 101", d); else passed++;
    axi_read(64'h00, d);
    total++;
    if (d !== 64'hA5) $display("FAIL single_data: got %h required a5", d); else passed++;
    axi_read(64'h08, d);
    total++;
    if (d !== 64'h0) $display("FAIL single_status_after: got %h required 0", d); else passed++;
  endtask

  task automatic test_glitch();
    logic [63:0] d;
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (4) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (30) @(negedge clk);
    axi_read(64'h08, d);
    total++;
    if (d !== 64'h0) $display("FAIL glitch_status: got %h required 0", d); else passed++;
    // A clean frame right after proves the receiver returned to IDLE.
    send_frame(8'h5A, 1'b1);
    axi_read(64'h00, d);
    total++;
    if (d !== 64'h5A) $display("FAIL glitch_next_byte: got %h required 5a", d); else passed++;
  endtask

  task automatic test_overflow();
    logic [63:0] d;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
    axi_read(64'h08, d);
    total++;
    if (d !== 64'h807) $display("FAIL ovr_status: got %h required 807", d); else passed++;
    for (int i = 1; i <= 8; i++) begin
      axi_read(64'h00, d);
      total++;
      if (d !== 64'(i)) $display("FAIL ovr_data[%0d]: got %h required %h", i, d, 64'(i));
      else passed++;
    end
    axi_read(64'h08, d);
    total++;
    if (d !== 64'h004) $display("FAIL ovr_sticky: got %h required 004", d); else passed++;
    axi_write(64'h10, 64'h2);
    axi_read(64'h08, d);
    total++;
    if (d !== 64'h0) $display("FAIL ovr_clear: got %h required 0", d); else passed++;
  endtask

  task automatic test_frame_error();
    logic [63:0] d;
    send_frame(8'h55, 1'b0);
    axi_read(64'h08, d);
    total++;
    if (d !== 64'h008) $display("FAIL ferr_status: got %h required 008", d); else passed++;
    axi_write(64'h10, 64'h2);
    axi_read(64'h08, d);
    total++;
    if (d !== 64'h0) $display("FAIL ferr_clear: got %h required 0", d); else passed++;
  endtask

  task automatic test_empty_read_hold();
    int n;
    @(negedge clk);
    bus.araddr  = 64'h0;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b0;
    n = 0;
    while (!bus.arready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.rvalid !== 1'b1 || bus.arready !== 1'b0 || bus.rdata !== 64'h8000_0000_0000_0000)
        $display("FAIL empty_hold[%0d]: rvalid=%b arready=%b rdata=%h required 1/0/8000000000000000",
                 i, bus.rvalid, bus.arready, bus.rdata);
      else passed++;
      @(negedge clk);
    end
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    total++;
    if (bus.rvalid !== 1'b0) $display("FAIL empty_release: rvalid=%b required 0", bus.rvalid);
    else passed++;
  endtask

  task automatic test_ctrl();
    logic [63:0] d;
    send_frame(8'h11, 1'b1);
    axi_write(64'h10, 64'h7);
    axi_read(64'h10, d);
    total++;
    if (d !== 64'h1) $display("FAIL ctrl_readback: got %h required 1", d); else passed++;
    axi_read(64'h1008, d);
    total++;
    if (d !== 64'h0) $display("FAIL ctrl_flush_status: got %h required 0", d); else passed++;
    axi_read(64'h18, d);
    total++;
    if (d !== 64'h0) $display("FAIL reserved_read: got %h required 0", d); else passed++;
    total++;
    if (irq !== 1'b0) $display("FAIL ctrl_irq_empty: irq=%b required 0", irq); else passed++;
  endtask

  task automatic test_irq_and_reset();
    logic [63:0] d;
    axi_write(64'h10, 64'h1);
    send_frame(8'h3C, 1'b1);
    total++;
    if (irq !== 1'b1) $display("FAIL irq_rise: irq=%b required 1", irq); else passed++;
    axi_read(64'h00, d);
    total++;
    if (d !== 64'h3C) $display("FAIL irq_data: got %h required 3c", d); else passed++;
    repeat (2) @(negedge clk);
    total++;
    if (irq !== 1'b0) $display("FAIL irq_fall: irq=%b required 0", irq); else passed++;
    // Leave one byte queued, then reset in the middle of the next frame's data bits.
    send_frame(8'h3C, 1'b1);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    total++;
    if (irq !== 1'b1) $display("FAIL irq_before_reset: irq=%b required 1", irq); else passed++;
    rstn = 1'b0;
    #1;
    total++;
    if (irq !== 1'b0) $display("FAIL irq_reset: irq=%b required 0", irq); else passed++;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    axi_read(64'h08, d);
    total++;
    if (d !== 64'h0) $display("FAIL reset_mid_frame_status: got %h required 0", d); else passed++;
    total++;
    if (irq !== 1'b0) $display("FAIL reset_mid_frame_irq: irq=%b required 0", irq); else passed++;
  endtask

  initial begin
    rstn        = 1'b0;
    uart_rxd    = 1'b1;
    bus.awaddr  = '0;
    bus.awvalid = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = '1;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    bus.araddr  = '0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    test_reset();
    test_single_byte();
    test_glitch();
    test_overflow();
    test_frame_error();
    test_empty_read_hold();
    test_ctrl();
    test_irq_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/axi_lite_uart_rx.md
Name: axi_lite_uart_rx

Overview:
- AXI-lite MMIO slave that receives asynchronous 8N1 serial bytes on one line and buffers them in a small FIFO.
- Software on the core polls or reads it through the MMIO hub, as a new slave window next to the timer, displayer, UART TX and MMU MMIO slaves.
- It is the receiving end of the serial link that the existing UART slave drives.
- Register map: offset 0x00 RXDATA, 0x08 STATUS, 0x10 CTRL; 0x18 reserved.

Parameters:
C_S_AXI_ADDR_WIDTH, 64, AXI-lite address width
C_S_AXI_DATA_WIDTH, 64, AXI-lite data width
CLK_PER_BIT, 16, clk cycles per serial bit; even, >= 4
FIFO_DEPTH, 8, RX FIFO entries; power of two, 2..16

Ports:
clk  in  1  single clock
rstn  in  1  asynchronous active-low reset
s_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
s_awvalid / s_awready  in/out  1  write-address handshake
s_wdata  in  C_S_AXI_DATA_WIDTH  write data
s_wstrb  in  C_S_AXI_DATA_WIDTH/8  byte strobes; ignored
s_wvalid / s_wready  in/out  1  write-data handshake
s_bresp  out  2  always 2'b00
s_bvalid / s_bready  out/in  1  write-response handshake
s_araddr  in  C_S_AXI_ADDR_WIDTH  read address
s_arvalid / s_arready  in/out  1  read-address handshake
s_rdata  out  C_S_AXI_DATA_WIDTH  read data
s_rresp  out  2  always 2'b00
s_rvalid / s_rready  out/in  1  read-data handshake
uart_rxd  in  1  serial input; idle high
irq  out  1  level interrupt, registered

Behaviour:
- Reset (rstn low, async): all ready/valid outputs 0; s_rdata 0; irq 0; FIFO empty; CTRL 0; sticky bits 0; RX FSM in IDLE.
- Reset mid-frame: the partial byte is discarded.
- uart_rxd passes through a 2-flop synchronizer (reset value 1).
- Only the synchronized value is used.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronized 1->0 edge; bit counter cleared.
  - START: after CLK_PER_BIT/2 cycles, sample the line. If 1, treat as a glitch and return to IDLE. If 0, go to DATA.
  - DATA: sample every CLK_PER_BIT cycles; 8 bits, LSB first, into a shift register.
  - STOP: sample after CLK_PER_BIT cycles. If 1, push the byte to the FIFO. If 0, set FERR, discard the byte, and stay in STOP until the line reads 1. Then return to IDLE.
- FIFO push when full: the byte is dropped and OVR is set.
- FIFO push and pop in the same cycle while full: both succeed; OVR is not set.
- STATUS read value:
  - bit0 = not-empty, bit1 = full, bit2 = OVR, bit3 = FERR, bit4 = PERR.
  - bits[12:8] = FIFO count; all other bits 0.
- CTRL:
  - bit0 IE is read/write.
  - Writing 1 to bit1 clears OVR, FERR and PERR.
  - Writing 1 to bit2 flushes the FIFO.
  - Bits 1 and 2 self-clear and read as 0.
- Register decode uses addr[4:3]; upper address bits are ignored.
- Read channel:
  - s_arready = !s_rvalid.
  - On an AR handshake, s_rvalid rises the next cycle.
  - s_rdata is held stable until the s_rready handshake.
  - At most one read is outstanding.
- RXDATA read:
  - If the FIFO is non-empty: returns {56'b0, byte} and pops the FIFO on the AR handshake cycle.
  - If the FIFO is empty: returns 64'h8000_0000_0000_0000 and does not pop.
  - Reading STATUS, CTRL or the reserved offset has no side effects; the reserved offset reads 0.
- Write channel:
  - s_awready and s_wready pulse together for 1 cycle when both valids are high and s_bvalid is low.
  - The register updates on that cycle.
  - s_bvalid rises the next cycle and is held until s_bready.
  - Writes to RXDATA, STATUS or the reserved offset are ignored, with OKAY response.
- Same-cycle FIFO flush and push: the flush wins and the FIFO ends empty.
- Same-cycle flush and RXDATA read: the read returns the pre-flush head.
- irq <= IE & not-empty; it updates one cycle after the state change.

Optional Feature:
- UART_RX_PARITY_EN defined:
  - Frame is 8E1; a PARITY state sits between DATA and STOP.
  - Even-parity mismatch sets PERR and discards the byte; the stop bit is still checked.
- UART_RX_PARITY_EN undefined:
  - Frame is 8N1; no PARITY state.
  - PERR (STATUS bit4) is tied to 0.

Test Plan:
- Serial byte 0xA5 at CLK_PER_BIT=16 -> STATUS reads 0x101; RXDATA reads 0xA5; STATUS then reads 0x000.
- uart_rxd low for 4 cycles, then high -> no push; STATUS 0x000; FSM back in IDLE.
- 9 back-to-back bytes 0x01..0x09, FIFO_DEPTH=8 -> STATUS 0x807; eight reads return 0x01..0x08.
- Byte with stop bit 0 -> FERR set and count 0. Write CTRL=0x2 -> STATUS 0x000.
- RXDATA read on an empty FIFO with s_rready held low 5 cycles -> s_rdata stays 0x8000_0000_0000_0000 and s_arready stays 0. After the handshake, s_rvalid drops.
- CTRL=0x1, then receive 0x3C -> irq rises 1 cycle after the push. Assert rstn low mid-DATA -> irq 0, FIFO empty, no byte is pushed afterwards.
